// File: rtl/if_fetch_if.sv
// Instruction memory request/acknowledge bus between the fetch stage and imem.
interface if_fetch_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    // Fetch stage drives the request, memory answers.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC generation, imem handshake, one-entry skid buffer
// and branch redirect with wrong-path squash, feeding the IF/ID register.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    if_fetch_if.master  imem,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);
    localparam int unsigned XLEN       = 32;
    localparam logic [XLEN-1:0] INST_BYTES = XLEN'(4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Registered state
    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_imem_req;
    logic [XLEN-1:0] r_imem_addr;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_inst;
    logic            r_if_valid;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] r_skid_inst;
    logic            r_skid_valid;

    // Next-state values
    state_t          w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic            w_imem_req_nxt;
    logic [XLEN-1:0] w_imem_addr_nxt;
    logic [XLEN-1:0] w_if_pc_nxt;
    logic [XLEN-1:0] w_if_inst_nxt;
    logic            w_if_valid_nxt;
    logic [XLEN-1:0] w_skid_pc_nxt;
    logic [XLEN-1:0] w_skid_inst_nxt;
    logic            w_skid_valid_nxt;

    logic            w_xfer;
    logic            w_slot_free;
    logic [XLEN-1:0] w_pc_inc;

    assign w_xfer      = r_if_valid && !stall;
    assign w_slot_free = !r_if_valid || w_xfer;
    assign w_pc_inc    = r_pc + INST_BYTES;

    // Next-state, fetch handshake, output slot and skid buffer control
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_imem_req_nxt   = r_imem_req;
        w_imem_addr_nxt  = r_imem_addr;
        w_if_pc_nxt      = r_if_pc;
        w_if_inst_nxt    = r_if_inst;
        w_if_valid_nxt   = r_if_valid;
        w_skid_pc_nxt    = r_skid_pc;
        w_skid_inst_nxt  = r_skid_inst;
        w_skid_valid_nxt = r_skid_valid;

        if (branch_flag_i) begin
            // Redirect squashes the offered and buffered instructions; if_pc/if_inst keep stale values.
            w_pc_nxt         = branch_target_i;
            w_if_valid_nxt   = 1'b0;
            w_skid_valid_nxt = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt     = ST_WAIT;
                    w_imem_req_nxt  = 1'b1;
                    w_imem_addr_nxt = branch_target_i;
                end
                ST_WAIT: begin
                    if (imem.imem_ack) begin
                        w_imem_addr_nxt = branch_target_i;
                    end else begin
                        // Request must stay stable; its response is thrown away later.
                        w_state_nxt = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (imem.imem_ack) begin
                        w_state_nxt     = ST_WAIT;
                        w_imem_addr_nxt = branch_target_i;
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_imem_req_nxt = 1'b0;
                end
            endcase
        end else begin
            // Drain the output slot: skid has priority over a freshly accepted word.
            if (w_xfer) begin
                if (r_skid_valid) begin
                    w_if_pc_nxt      = r_skid_pc;
                    w_if_inst_nxt    = r_skid_inst;
                    w_if_valid_nxt   = 1'b1;
                    w_skid_valid_nxt = 1'b0;
                end else begin
                    w_if_valid_nxt = 1'b0;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (!r_skid_valid) begin
                        w_state_nxt     = ST_WAIT;
                        w_imem_req_nxt  = 1'b1;
                        w_imem_addr_nxt = r_pc;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_ack) begin
                        w_pc_nxt = w_pc_inc;
                        if (w_slot_free) begin
                            // Back-to-back fetch while the consumer keeps up.
                            w_if_pc_nxt     = r_imem_addr;
                            w_if_inst_nxt   = imem.imem_rdata;
                            w_if_valid_nxt  = 1'b1;
                            w_imem_addr_nxt = w_pc_inc;
                        end else begin
                            // Consumer stalled: park the word and stop requesting.
                            w_skid_pc_nxt    = r_imem_addr;
                            w_skid_inst_nxt  = imem.imem_rdata;
                            w_skid_valid_nxt = 1'b1;
                            w_state_nxt      = ST_IDLE;
                            w_imem_req_nxt   = 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    if (imem.imem_ack) begin
                        w_state_nxt     = ST_WAIT;
                        w_imem_addr_nxt = r_pc;
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_imem_req_nxt = 1'b0;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_imem_req   <= 1'b0;
            r_imem_addr  <= RESET_PC;
            r_if_pc      <= '0;
            r_if_inst    <= '0;
            r_if_valid   <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_inst  <= '0;
            r_skid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_imem_req   <= w_imem_req_nxt;
            r_imem_addr  <= w_imem_addr_nxt;
            r_if_pc      <= w_if_pc_nxt;
            r_if_inst    <= w_if_inst_nxt;
            r_if_valid   <= w_if_valid_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
            r_skid_inst  <= w_skid_inst_nxt;
            r_skid_valid <= w_skid_valid_nxt;
        end
    end

    assign imem.imem_req  = r_imem_req;
    assign imem.imem_addr = r_imem_addr;
    assign if_pc          = r_if_pc;
    assign if_inst        = r_if_inst;
    assign if_valid       = r_if_valid;
endmodule
